// File: rtl/quad_rot_pkg.sv
// Shared definitions for the rotary-encoder position counter:
// quadrature FSM state encoding, direction constants and phase helpers.
package quad_rot_pkg;

    typedef enum logic [2:0] {
        ST_RESYNC = 3'd0,
        ST_IDLE   = 3'd1,
        ST_CW1    = 3'd2,
        ST_CW2    = 3'd3,
        ST_CW3    = 3'd4,
        ST_CCW1   = 3'd5,
        ST_CCW2   = 3'd6,
        ST_CCW3   = 3'd7
    } quad_state_e;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_01 = 2'b01;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_10 = 2'b10;

    // Filtered {A,B} pair that each tracking state expects to be sitting on.
    function automatic logic [1:0] state_pair(input quad_state_e st);
        logic [1:0] pair;
        case (st)
            ST_IDLE:  pair = AB_00;
            ST_CW1:   pair = AB_01;
            ST_CW2:   pair = AB_11;
            ST_CW3:   pair = AB_10;
            ST_CCW1:  pair = AB_10;
            ST_CCW2:  pair = AB_11;
            ST_CCW3:  pair = AB_01;
            default:  pair = AB_00;
        endcase
        return pair;
    endfunction

    // Both channels moving at once cannot come from a real quadrature encoder.
    function automatic logic both_changed(input logic [1:0] from_ab,
                                          input logic [1:0] to_ab);
        return ((from_ab ^ to_ab) == 2'b11);
    endfunction

endpackage

// File: rtl/quad_rot_counter_debounce_filter.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce window
// for one raw encoder channel; also reports when the first window completed.
module debounce_filter
    import quad_rot_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o,
    output logic valid_o
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             last_q;
    logic             filt_q;
    logic             filt_d;
    logic             valid_q;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] run_len;
    logic             count_en;
    logic             window_done;

    // Until the first window completes, any stable level counts (so the
    // flag can set even when the value never changes); afterwards only a
    // level that differs from the filtered one is timed.
    always_comb begin
        count_en    = (sync2_q != filt_q) || !valid_q;
        run_len     = (sync2_q != last_q) ? CNT_W'(1) : (cnt_q + CNT_W'(1));
        window_done = count_en && (run_len == CNT_W'(DB_CYCLES));
        if (!count_en) begin
            cnt_d = '0;
        end else if (window_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = run_len;
        end
        if (window_done) begin
            filt_d  = sync2_q;
            valid_d = 1'b1;
        end else begin
            filt_d  = filt_q;
            valid_d = valid_q;
        end
    end

    // Synchroniser, change detector and debounce state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
            filt_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            filt_q  <= filt_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o  = filt_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/quad_rot_counter.sv
// Rotary encoder position counter: debounced quadrature channels feed a
// detent-tracking FSM that steps a 3-bit wrapping position.
module quad_rot_counter
    import quad_rot_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       enable,
    output logic [2:0] bin_rot,
    output logic       step_pulse,
    output logic       dir,
    output logic       err
);

    logic        filt_a;
    logic        filt_b;
    logic        valid_a;
    logic        valid_b;
    logic [1:0]  ab;

    quad_state_e state_q;
    logic [2:0]  bin_rot_q;
    logic        step_q;
    logic        dir_q;
    logic        err_q;

    debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_filt_a (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (enc_a),
        .filt_o  (filt_a),
        .valid_o (valid_a)
    );

    debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_filt_b (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (enc_b),
        .filt_o  (filt_b),
        .valid_o (valid_b)
    );

    assign ab = {filt_a, filt_b};

    // Detent tracker with registered position, direction and pulses.
    // A finished detent is only applied when enable is high, but the
    // tracking itself never stops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RESYNC;
            bin_rot_q <= 3'b000;
            step_q    <= 1'b0;
            dir_q     <= DIR_CCW;
            err_q     <= 1'b0;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_RESYNC: begin
                    if (valid_a && valid_b && (ab == AB_00)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESYNC;
                    end
                end
                ST_IDLE, ST_CW1, ST_CW2, ST_CW3, ST_CCW1, ST_CCW2, ST_CCW3: begin
                    if (both_changed(state_pair(state_q), ab)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_RESYNC;
                    end else begin
                        case (state_q)
                            ST_IDLE: begin
                                if (ab == AB_01) begin
                                    state_q <= ST_CW1;
                                end else if (ab == AB_10) begin
                                    state_q <= ST_CCW1;
                                end else begin
                                    state_q <= ST_IDLE;
                                end
                            end
                            ST_CW1: begin
                                if (ab == AB_11) begin
                                    state_q <= ST_CW2;
                                end else if (ab == AB_00) begin
                                    state_q <= ST_IDLE;
                                end else begin
                                    state_q <= ST_CW1;
                                end
                            end
                            ST_CW2: begin
                                if (ab == AB_10) begin
                                    state_q <= ST_CW3;
                                end else if (ab == AB_01) begin
                                    state_q <= ST_CW1;
                                end else begin
                                    state_q <= ST_CW2;
                                end
                            end
                            ST_CW3: begin
                                if (ab == AB_00) begin
                                    state_q <= ST_IDLE;
                                    if (enable) begin
                                        bin_rot_q <= bin_rot_q + 3'd1;
                                        step_q    <= 1'b1;
                                        dir_q     <= DIR_CW;
                                    end else begin
                                        bin_rot_q <= bin_rot_q;
                                    end
                                end else if (ab == AB_11) begin
                                    state_q <= ST_CW2;
                                end else begin
                                    state_q <= ST_CW3;
                                end
                            end
                            ST_CCW1: begin
                                if (ab == AB_11) begin
                                    state_q <= ST_CCW2;
                                end else if (ab == AB_00) begin
                                    state_q <= ST_IDLE;
                                end else begin
                                    state_q <= ST_CCW1;
                                end
                            end
                            ST_CCW2: begin
                                if (ab == AB_01) begin
                                    state_q <= ST_CCW3;
                                end else if (ab == AB_10) begin
                                    state_q <= ST_CCW1;
                                end else begin
                                    state_q <= ST_CCW2;
                                end
                            end
                            ST_CCW3: begin
                                if (ab == AB_00) begin
                                    state_q <= ST_IDLE;
                                    if (enable) begin
                                        bin_rot_q <= bin_rot_q - 3'd1;
                                        step_q    <= 1'b1;
                                        dir_q     <= DIR_CCW;
                                    end else begin
                                        bin_rot_q <= bin_rot_q;
                                    end
                                end else if (ab == AB_11) begin
                                    state_q <= ST_CCW2;
                                end else begin
                                    state_q <= ST_CCW3;
                                end
                            end
                            default: state_q <= ST_RESYNC;
                        endcase
                    end
                end
                default: state_q <= ST_RESYNC;
            endcase
        end
    end

    assign bin_rot    = bin_rot_q;
    assign step_pulse = step_q;
    assign dir        = dir_q;
    assign err        = err_q;

endmodule

// File: tb/tb_quad_rot_counter.sv
// Randomised and directed bench for quad_rot_counter, checked every cycle
// against a phase-arithmetic model of the encoder, plus literal spot checks.
module tb_quad_rot_counter;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       enable;
    logic [2:0] bin_rot;
    logic       step_pulse;
    logic       dir;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;
    int dut_steps   = 0;
    int dut_errs    = 0;
    bit chk_on      = 1'b0;

    // Reference model state: synchronised, filtered and phase tracking.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_filt [2];
    bit m_valid [2];
    bit m_hist [2][DB];
    int m_hn [2];
    bit m_resync;
    int m_off;
    int m_bin;
    bit m_step;
    bit m_dir;
    bit m_err;

    always #5 clk = ~clk;

    quad_rot_counter #(.DB_CYCLES(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .enable     (enable),
        .bin_rot    (bin_rot),
        .step_pulse (step_pulse),
        .dir        (dir),
        .err        (err)
    );

    // Gray phase index of a quadrature pair, going clockwise 00,01,11,10.
    function automatic int gray(input bit a, input bit b);
        case ({a, b})
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: a detent is a net phase displacement of +/-4 from the rest
    // position; a jump of two phases is illegal and forces a resync.
    always @(posedge clk) begin : model
        int  g;
        int  d;
        int  off;
        int  bn;
        bit  rs;
        bit  stp;
        bit  er;
        bit  dr;
        bit  nf [2];
        bit  nv [2];
        bit  nh [2][DB];
        int  nn [2];
        bit  alleq;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c]    <= 1'b0;
                m_s2[c]    <= 1'b0;
                m_filt[c]  <= 1'b0;
                m_valid[c] <= 1'b0;
                m_hn[c]    <= 0;
            end
            m_resync <= 1'b1;
            m_off    <= 0;
            m_bin    <= 0;
            m_step   <= 1'b0;
            m_dir    <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            off = m_off; rs = m_resync; bn = m_bin; dr = m_dir; stp = 1'b0; er = 1'b0;
            g = gray(m_filt[0], m_filt[1]);
            if (rs) begin
                if (m_valid[0] && m_valid[1] && g == 0) begin
                    rs = 1'b0;
                    off = 0;
                end
            end else begin
                d = (g - (((off % 4) + 4) % 4) + 4) % 4;
                if (d == 2) begin
                    er = 1'b1;
                    rs = 1'b1;
                    off = 0;
                end else if (d == 1) begin
                    off = off + 1;
                end else if (d == 3) begin
                    off = off - 1;
                end
                if (off == 4 || off == -4) begin
                    if (enable) begin
                        bn  = (off > 0) ? (bn + 1) % 8 : (bn + 7) % 8;
                        stp = 1'b1;
                        dr  = (off > 0);
                    end
                    off = 0;
                end
            end
            for (int c = 0; c < 2; c++) begin
                nf[c] = m_filt[c];
                nv[c] = m_valid[c];
                nn[c] = (m_hn[c] < DB) ? m_hn[c] + 1 : DB;
                for (int i = 0; i < DB - 1; i++) nh[c][i] = m_hist[c][i+1];
                nh[c][DB-1] = m_s2[c];
                if (nn[c] == DB) begin
                    alleq = 1'b1;
                    for (int i = 0; i < DB; i++) if (nh[c][i] != nh[c][DB-1]) alleq = 1'b0;
                    if (alleq && (!m_valid[c] || nh[c][DB-1] != m_filt[c])) begin
                        nf[c] = nh[c][DB-1];
                        nv[c] = 1'b1;
                        nn[c] = 0;
                    end
                end
            end
            m_resync <= rs; m_off <= off; m_bin <= bn; m_dir <= dr; m_step <= stp; m_err <= er;
            m_hist <= nh; m_hn <= nn; m_filt <= nf; m_valid <= nv;
            m_s2 <= m_s1;
            m_s1[0] <= enc_a;
            m_s1[1] <= enc_b;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("bin_rot", bin_rot, m_bin);
            check("step_pulse", step_pulse, m_step);
            check("dir", dir, m_dir);
            check("err", err, m_err);
        end
        if (step_pulse === 1'b1) dut_steps++;
        if (err === 1'b1) dut_errs++;
    end

    task automatic hold(input bit a, input bit b, input int n);
        enc_a = a;
        enc_b = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic cw_seq();
        hold(1'b0, 1'b1, 10); hold(1'b1, 1'b1, 10); hold(1'b1, 1'b0, 10); hold(1'b0, 1'b0, 10);
    endtask

    task automatic ccw_seq();
        hold(1'b1, 1'b0, 10); hold(1'b1, 1'b1, 10); hold(1'b0, 1'b1, 10); hold(1'b0, 1'b0, 10);
    endtask

    initial begin
        int s0;
        int e0;
        int lat;
        int gp;
        int r;
        reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("rst_bin", bin_rot, 0);
        check("rst_step", step_pulse, 0);
        check("rst_dir", dir, 0);
        check("rst_err", err, 0);
        reset = 1'b0;

        hold(1'b0, 1'b0, 20);
        check("settle_bin", bin_rot, 0);
        check("settle_errs", dut_errs, 0);

        s0 = dut_steps;
        cw_seq();
        check("cw_bin", bin_rot, 1);
        check("cw_steps", dut_steps - s0, 1);
        check("cw_dir", dir, 1);

        ccw_seq();
        check("ccw_to0", bin_rot, 0);
        s0 = dut_steps;
        for (int k = 1; k <= 8; k++) begin
            ccw_seq();
            check("ccw_wrap_bin", bin_rot, (8 - k) % 8);
        end
        check("ccw_steps", dut_steps - s0, 8);
        check("ccw_dir", dir, 0);

        s0 = dut_steps; e0 = dut_errs;
        for (int k = 0; k < 15; k++) hold(k % 2 == 0, 1'b0, 2);
        hold(1'b0, 1'b0, 10);
        check("bounce_steps", dut_steps - s0, 0);
        check("bounce_errs", dut_errs - e0, 0);

        e0 = dut_errs;
        hold(1'b1, 1'b1, 10);
        check("jump_err", dut_errs - e0, 1);
        hold(1'b0, 1'b0, 10);
        cw_seq();
        check("post_jump_bin", bin_rot, 1);

        s0 = dut_steps;
        hold(1'b0, 1'b1, 10); hold(1'b1, 1'b1, 10); hold(1'b0, 1'b1, 10); hold(1'b0, 1'b0, 10);
        check("partial_bin", bin_rot, 1);
        enable = 1'b0;
        cw_seq();
        enable = 1'b1;
        check("disabled_bin", bin_rot, 1);
        check("disabled_steps", dut_steps - s0, 0);
        cw_seq();
        check("reenabled_bin", bin_rot, 2);

        hold(1'b0, 1'b1, 10); hold(1'b1, 1'b1, 10); hold(1'b1, 1'b0, 10);
        enc_a = 1'b0; enc_b = 1'b0;
        lat = 0;
        while (lat < 20 && step_pulse !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
        check("latency_in_range", (lat >= 6 && lat <= 8), 1);
        hold(1'b0, 1'b0, 10);
        check("latency_bin", bin_rot, 3);

        hold(1'b0, 1'b1, 10); hold(1'b1, 1'b1, 10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_bin", bin_rot, 0);
        hold(1'b1, 1'b1, 20);
        hold(1'b0, 1'b0, 20);
        cw_seq();
        check("midreset_cw_bin", bin_rot, 1);

        gp = 0;
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            enable = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 9);
            if (r < 4) gp = (gp + 1) % 4;
            else if (r < 8) gp = (gp + 3) % 4;
            else if (r == 8) gp = (gp + 2) % 4;
            hold(gp == 2 || gp == 3, gp == 1 || gp == 2,
                 ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 12));
        end
        enable = 1'b1;
        hold(1'b0, 1'b0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/quad_rot_counter.md
QUAD_ROT_COUNTER -- requirements
Module: quad_rot_counter

Interface
REQ-001 Parameter DB_CYCLES, default 250000, sets the consecutive clk cycles a synchronised channel must hold stable before its filtered value updates (2 ms at 125 MHz).
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 enc_a  input  1  raw quadrature channel A from the rotary encoder; asynchronous, bouncing.
REQ-005 enc_b  input  1  raw quadrature channel B from the rotary encoder; asynchronous, bouncing.
REQ-006 enable  input  1  when high, completed detents update the position; when low, the position SHALL hold.
REQ-007 bin_rot  output  3  registered position count, feeding the downstream LED direction decoder.
REQ-008 step_pulse  output  1  one-cycle pulse on each position update.
REQ-009 dir  output  1  direction of the last counted detent: 1 = clockwise (CW), 0 = counter-clockwise (CCW).
REQ-010 err  output  1  one-cycle pulse on an illegal quadrature transition.

Function
REQ-011 Each raw channel SHALL pass through a two-flop synchroniser before any other use.
REQ-012 Debounce: the filtered value SHALL take the synchronised value once that value has differed from the filtered value for DB_CYCLES consecutive cycles; any reversion SHALL restart the window.
REQ-013 Each channel SHALL set a sticky valid flag on completing its first stable window after reset, whether or not the filtered value changed.
REQ-014 The quadrature FSM SHALL act on the filtered pair {A,B}. States: RESYNC, IDLE(00), CW1(01), CW2(11), CW3(10), CCW1(10), CCW2(11), CCW3(01).
REQ-015 RESYNC SHALL move to IDLE only when both valid flags are set and the filtered pair is 00; no err SHALL be raised in RESYNC.
REQ-016 Forward transitions SHALL be: IDLE->CW1 on 01; CW1->CW2 on 11; CW2->CW3 on 10; CW3->IDLE on 00 with a CW count.
REQ-017 Backward transitions SHALL be: IDLE->CCW1 on 10; CCW1->CCW2 on 11; CCW2->CCW3 on 01; CCW3->IDLE on 00 with a CCW count.
REQ-018 A one-step reversal SHALL return to the previous state without counting (e.g. CW2 on 01 -> CW1; CW1 on 00 -> IDLE).
REQ-019 A change of both filtered bits in one cycle SHALL pulse err and enter RESYNC with no count.
REQ-020 On a count with enable high: bin_rot +1 mod 8 for CW and -1 mod 8 for CCW (7->0 and 0->7 wrap), step_pulse high one cycle, dir updated; all of these SHALL occur in the cycle after the filtered 00 is registered.
REQ-021 A count with enable low SHALL be discarded: bin_rot, dir and step_pulse unchanged. The FSM SHALL still track.
REQ-022 End-to-end latency from a clean raw edge to a bin_rot update SHALL be 2 (sync) + DB_CYCLES + 1 cycles, within +/-1 cycle.

Reset
REQ-023 Reset SHALL set synchronisers and filtered values to 0, valid flags to 0, debounce counters to 0, FSM to RESYNC, and bin_rot=3'b000, step_pulse=0, dir=0, err=0.
REQ-024 Reset asserted mid-detent SHALL discard the partial detent; counting resumes only after the RESYNC exit condition.

Structure
REQ-025 Package quad_rot_pkg SHALL hold the FSM state encoding and the DIR_CW/DIR_CCW constants.
REQ-026 The synchroniser plus debounce SHALL be one sub-module, debounce_filter, instantiated once per channel and outputting filtered value and valid flag.

Verification (DB_CYCLES=4, each input level held 10 cycles)
REQ-027 Reset with A=B=0, then hold -> FSM reaches IDLE after about 7 cycles; bin_rot=0; err never pulses.
REQ-028 From IDLE, one CW sequence 00,01,11,10,00 -> bin_rot 0->1, exactly one step_pulse, dir=1.
REQ-029 From bin_rot=0, eight CCW sequences -> bin_rot 7,6,...,0 with eight step_pulses, dir=0.
REQ-030 A toggles every 2 cycles for 30 cycles, then returns to 0 -> filtered A unchanged, no step_pulse, no err.
REQ-031 From IDLE, A,B jump 00->11 -> one err pulse and RESYNC; after returning to 00, one CW sequence -> bin_rot +1.
REQ-032 Partial sequence 00,01,11,01,00 -> no count. A full CW sequence with enable=0 -> bin_rot unchanged, step_pulse low.
